// File: rtl/dcache_sram0_pkg.sv
// Shared sizing constants and word/address types for the D-cache way-0 data SRAM.
package dcache_sram0_pkg;

    localparam int ADDR_WIDTH = 9;
    localparam int DATA_WIDTH = 32;
    localparam int BYTE_SIZE  = 8;
    localparam int BE_WIDTH   = DATA_WIDTH / BYTE_SIZE;
    localparam int DEPTH      = 2 ** ADDR_WIDTH;

    typedef logic [ADDR_WIDTH-1:0] addr_t;
    typedef logic [DATA_WIDTH-1:0] word_t;
    typedef logic [BYTE_SIZE-1:0]  byte_t;
    typedef logic [BE_WIDTH-1:0]   be_t;

endpackage

// File: rtl/dcache_sram0_byte_lane.sv
// One byte lane of the way-0 data SRAM: single write port, single registered read port.
module dcache_sram0_byte_lane #(
    parameter int ADDR_WIDTH = dcache_sram0_pkg::ADDR_WIDTH,
    parameter int LANE_WIDTH = dcache_sram0_pkg::BYTE_SIZE
) (
    input  logic                  wr_clk,
    input  logic                  wr_rst,
    input  logic                  rd_clk,
    input  logic                  rd_rst,
    input  logic                  wr_en,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [LANE_WIDTH-1:0] wr_data,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    output logic [LANE_WIDTH-1:0] rd_data
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;

    // Array is never reset; contents are undefined until written.
    logic [LANE_WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge wr_clk) begin
        if (wr_en && !wr_rst) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // Non-blocking update gives read-before-write on a shared-edge collision.
    always_ff @(posedge rd_clk or posedge rd_rst) begin
        if (rd_rst) begin
            rd_data <= '0;
        end else begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/dcache_sram0.sv
// Way-0 D-cache data SRAM: 512x32 simple dual-port, byte-enabled writes, registered reads.
// Optional DCACHE_SRAM0_OUTPUT_REG_EN adds a second rd_clk output stage (2-cycle read latency).
module dcache_sram0 #(
    parameter int ADDR_WIDTH = dcache_sram0_pkg::ADDR_WIDTH,
    parameter int DATA_WIDTH = dcache_sram0_pkg::DATA_WIDTH,
    parameter int BE_WIDTH   = dcache_sram0_pkg::BE_WIDTH
) (
    input  logic                  wr_clk,
    input  logic                  wr_rst,
    input  logic                  rd_clk,
    input  logic                  rd_rst,
    input  logic                  wr_en,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic [BE_WIDTH-1:0]   wr_byte_en,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    output logic [DATA_WIDTH-1:0] rd_data
);

    import dcache_sram0_pkg::*;

    logic [DATA_WIDTH-1:0] lane_q;

    for (genvar i = 0; i < BE_WIDTH; i++) begin : g_lane
        dcache_sram0_byte_lane #(
            .ADDR_WIDTH (ADDR_WIDTH),
            .LANE_WIDTH (BYTE_SIZE)
        ) u_lane (
            .wr_clk  (wr_clk),
            .wr_rst  (wr_rst),
            .rd_clk  (rd_clk),
            .rd_rst  (rd_rst),
            .wr_en   (wr_en & wr_byte_en[i]),
            .wr_addr (wr_addr),
            .wr_data (wr_data[i*BYTE_SIZE +: BYTE_SIZE]),
            .rd_addr (rd_addr),
            .rd_data (lane_q[i*BYTE_SIZE +: BYTE_SIZE])
        );
    end

`ifdef DCACHE_SRAM0_OUTPUT_REG_EN
    logic [DATA_WIDTH-1:0] out_q;

    always_ff @(posedge rd_clk or posedge rd_rst) begin
        if (rd_rst) begin
            out_q <= '0;
        end else begin
            out_q <= lane_q;
        end
    end

    assign rd_data = out_q;
`else
    assign rd_data = lane_q;
`endif

endmodule

// File: tb/tb_dcache_sram0.sv
// Directed self-checking bench for dcache_sram0 (honours DCACHE_SRAM0_OUTPUT_REG_EN).
module tb_dcache_sram0;

`ifdef DCACHE_SRAM0_OUTPUT_REG_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    logic        wr_clk = 1'b0;
    logic        rd_clk = 1'b0;
    logic        tb_wr_rst;
    logic        rd_rst;
    logic        wr_en;
    logic [8:0]  wr_addr;
    logic [31:0] wr_data;
    logic [3:0]  wr_byte_en;
    logic [8:0]  rd_addr;
    logic [31:0] rd_data;

    logic [31:0] exp_mem [512];
    int          n_assert = 0;
    int          n_fail   = 0;

    always #5 wr_clk = ~wr_clk;
    always #5 rd_clk = ~rd_clk;

    dcache_sram0 #(
        .ADDR_WIDTH (9),
        .DATA_WIDTH (32),
        .BE_WIDTH   (4)
    ) dut (
        .wr_clk     (wr_clk),
        .wr_rst     (tb_wr_rst),
        .rd_clk     (rd_clk),
        .rd_rst     (rd_rst),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .wr_byte_en (wr_byte_en),
        .rd_addr    (rd_addr),
        .rd_data    (rd_data)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic write_word(input logic [8:0] a, input logic [31:0] d, input logic [3:0] be);
        @(negedge wr_clk);
        wr_en      = 1'b1;
        wr_addr    = a;
        wr_data    = d;
        wr_byte_en = be;
        @(negedge wr_clk);
        wr_en      = 1'b0;
    endtask

    task automatic read_check(input logic [8:0] a, input logic [31:0] exp, input string tag);
        rd_addr = a;
        repeat (LAT) @(posedge rd_clk);
        @(negedge rd_clk);
        check(tag, rd_data, exp);
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] d;
        int          j;

        // Both resets held 200 ns with a write attempted throughout.
        tb_wr_rst  = 1'b1;
        rd_rst     = 1'b1;
        wr_en      = 1'b1;
        wr_addr    = 9'd3;
        wr_data    = 32'h5555_AAAA;
        wr_byte_en = 4'hF;
        rd_addr    = 9'd3;
        #3;
        check("reset_t3", rd_data, 32'h0);
        for (int c = 0; c < 19; c++) begin
            @(negedge rd_clk);
            if (c % 6 == 0) check("reset_hold", rd_data, 32'h0);
        end
        @(negedge rd_clk);
        wr_en     = 1'b0;
        tb_wr_rst = 1'b0;
        rd_rst    = 1'b0;
        #1;
        check("reset_release", rd_data, 32'h0);

        // Full write: addr 1..511 then 0, decrementing data.
        for (int k = 0; k < 512; k++) begin
            @(negedge wr_clk);
            d          = (k == 511) ? 32'hFFFF_FE01 : 32'hFFFF_FFFF - 32'(k);
            wr_en      = 1'b1;
            wr_addr    = 9'((k + 1) % 512);
            wr_data    = d;
            wr_byte_en = 4'hF;
            exp_mem[(k + 1) % 512] = d;
        end
        @(negedge wr_clk);
        wr_en = 1'b0;

        // Streamed read: one new address per cycle, data LAT cycles later.
        for (int i = 0; i < 512 + LAT - 1; i++) begin
            if (i < 512) rd_addr = 9'((i + 1) % 512);
            @(posedge rd_clk);
            @(negedge rd_clk);
            j = i - LAT + 1;
            if (j >= 0) begin
                n_assert++;
                assert (rd_data === exp_mem[(j + 1) % 512]) else begin
                    n_fail++;
                    $error("FAIL full_rd addr %0d: observed %h expected %h",
                           (j + 1) % 512, rd_data, exp_mem[(j + 1) % 512]);
                end
            end
        end
        read_check(9'd1,   32'hFFFF_FFFF, "spot_addr1");
        read_check(9'd0,   32'hFFFF_FE01, "spot_addr0");
        read_check(9'd511, 32'hFFFF_FE01, "spot_addr511");

        // Byte enables: lanes 0 and 2 take new data.
        write_word(9'd5, 32'hAABB_CCDD, 4'hF);
        read_check(9'd5, 32'hAABB_CCDD, "be_full");
        write_word(9'd5, 32'h1122_3344, 4'b0101);
        read_check(9'd5, 32'hAA22_CC44, "be_0101");
        write_word(9'd5, 32'h9988_7766, 4'b1000);
        read_check(9'd5, 32'h9922_CC44, "be_1000");

        // Collision on a shared edge returns the old word.
        write_word(9'd7, 32'hDEAD_BEEF, 4'hF);
        rd_addr = 9'd0;
        @(negedge wr_clk);
        wr_en      = 1'b1;
        wr_addr    = 9'd7;
        wr_data    = 32'h1234_5678;
        wr_byte_en = 4'hF;
        rd_addr    = 9'd7;
        @(posedge wr_clk);
        @(negedge wr_clk);
        wr_en = 1'b0;
        repeat (LAT - 1) begin
            @(posedge rd_clk);
            @(negedge rd_clk);
        end
        check("collide_old", rd_data, 32'hDEAD_BEEF);
        @(posedge rd_clk);
        @(negedge rd_clk);
        check("collide_new", rd_data, 32'h1234_5678);

        // rd_rst mid-stream clears output asynchronously; memory survives.
        rd_addr = 9'd2;
        repeat (LAT) @(posedge rd_clk);
        @(negedge rd_clk);
        check("pre_rdrst", rd_data, 32'hFFFF_FFFE);
        #2;
        rd_rst = 1'b1;
        #1;
        check("rdrst_async", rd_data, 32'h0);
        @(posedge rd_clk);
        @(negedge rd_clk);
        check("rdrst_hold", rd_data, 32'h0);
        rd_rst = 1'b0;
        #1;
        check("rdrst_release", rd_data, 32'h0);
        read_check(9'd2, 32'hFFFF_FFFE, "post_rdrst");

        // wr_rst during a write drops it; neighbouring writes land.
        @(negedge wr_clk);
        wr_en      = 1'b1;
        wr_addr    = 9'd6;
        wr_data    = 32'h0BAD_F00D;
        wr_byte_en = 4'hF;
        @(negedge wr_clk);
        tb_wr_rst  = 1'b1;
        wr_addr    = 9'd7;
        wr_data    = 32'hCAFE_F00D;
        @(negedge wr_clk);
        tb_wr_rst  = 1'b0;
        wr_addr    = 9'd8;
        wr_data    = 32'h600D_CAFE;
        @(negedge wr_clk);
        wr_en = 1'b0;
        read_check(9'd7, 32'h1234_5678, "wrrst_blocked");
        read_check(9'd6, 32'h0BAD_F00D, "wrrst_before");
        read_check(9'd8, 32'h600D_CAFE, "wrrst_after");

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
